// File: rtl/da_lut_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : da_lut_loader_if
// Description : Coefficient stream, control/status and SRAM write-port bundle
//               for the distributed-arithmetic partial-sum table loader.
//               master = loader side, slave = coefficient source / SRAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface da_lut_loader_if #(
  parameter int COEF_W = 16,
  parameter int DW     = 20
);
  logic              start;
  logic [COEF_W-1:0] coef_data;
  logic              coef_valid;
  logic              coef_ready;
  logic [10:0]       sram_caddr;
  logic [DW-1:0]     sram_d;
  logic              sram_wen;
  logic              sram_cen;
  logic              busy;
  logic              done;

  modport master (
    input  start, coef_data, coef_valid,
    output coef_ready, sram_caddr, sram_d, sram_wen, sram_cen, busy, done
  );

  modport slave (
    output start, coef_data, coef_valid,
    input  coef_ready, sram_caddr, sram_d, sram_wen, sram_cen, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/da_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : da_lut_loader
// Description : Accepts 64 signed coefficients, computes all 2048 DA partial
//               sums on the fly and sweeps them into the 8-block SRAM, then
//               releases the SRAM for filter reads. All outputs registered.
//               DW must be at least COEF_W+3 so an 8-term sum cannot overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module da_lut_loader #(
  parameter int COEF_W = 16,
  parameter int DW     = 20
) (
  input  logic              clk,
  input  logic              rst,
  da_lut_loader_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_FLUSH = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  localparam logic [5:0]  c_LAST_COEF = 6'd63;
  localparam logic [10:0] c_LAST_ADDR = 11'd2047;

  state_t            r_state, w_state_nxt;
  // Shared counter: coefficient index in LOAD, SRAM address in WRITE/FLUSH.
  logic [10:0]       r_cnt, w_cnt_nxt;
  logic [COEF_W-1:0] r_coef [64];
  logic              w_hs;
  logic [DW-1:0]     w_entry;

  logic              r_coef_ready, w_ready_nxt;
  logic [10:0]       r_caddr, w_caddr_nxt;
  logic [DW-1:0]     r_d, w_d_nxt;
  logic              r_wen, w_wen_nxt;
  logic              r_cen, w_cen_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  function automatic logic [DW-1:0] sext(input logic [COEF_W-1:0] v);
    return {{(DW-COEF_W){v[COEF_W-1]}}, v};
  endfunction

  // coef_ready is only ever high in LOAD, so it doubles as the state qualifier.
  assign w_hs = bus.coef_valid & r_coef_ready;

  // State and counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Coefficient store; contents are don't-care until a full load completes.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_coef[r_cnt[5:0]] <= bus.coef_data;
    end
  end

  // Partial sum for the address about to be presented: block selects the
  // coefficient group, each address bit selects one tap of that group.
  always_comb begin
    w_entry = '0;
    for (int j = 0; j < 8; j++) begin
      if (w_cnt_nxt[j]) begin
        w_entry = w_entry + sext(r_coef[{w_cnt_nxt[10:8], 3'(j)}]);
      end
    end
  end

  // Next-state, counter and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          if (r_cnt[5:0] == c_LAST_COEF) begin
            w_state_nxt = S_WRITE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 11'd1;
          end
        end
      end
      S_WRITE: begin
        if (r_cnt == c_LAST_ADDR) begin
          w_state_nxt = S_FLUSH;
        end else begin
          w_cnt_nxt = r_cnt + 11'd1;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
      S_RUN: begin
        if (bus.start) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_ready_nxt = (w_state_nxt == S_LOAD);
    w_busy_nxt  = (w_state_nxt == S_LOAD) || (w_state_nxt == S_WRITE) ||
                  (w_state_nxt == S_FLUSH);
    w_done_nxt  = (w_state_nxt == S_RUN);
    w_cen_nxt   = !((w_state_nxt == S_WRITE) || (w_state_nxt == S_FLUSH) ||
                    (w_state_nxt == S_RUN));
    // The SRAM registers the address one edge late, so write enable trails the
    // address by a cycle: low in every cycle that follows a WRITE cycle.
    w_wen_nxt   = (r_state != S_WRITE);
    w_caddr_nxt = '0;
    w_d_nxt     = '0;
    if (w_state_nxt == S_WRITE) begin
      w_caddr_nxt = w_cnt_nxt;
      w_d_nxt     = w_entry;
    end else if (w_state_nxt == S_FLUSH) begin
      w_caddr_nxt = w_cnt_nxt;
      w_d_nxt     = r_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_coef_ready <= 1'b0;
      r_caddr      <= '0;
      r_d          <= '0;
      r_wen        <= 1'b1;
      r_cen        <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_coef_ready <= w_ready_nxt;
      r_caddr      <= w_caddr_nxt;
      r_d          <= w_d_nxt;
      r_wen        <= w_wen_nxt;
      r_cen        <= w_cen_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign bus.coef_ready = r_coef_ready;
  assign bus.sram_caddr = r_caddr;
  assign bus.sram_d     = r_d;
  assign bus.sram_wen   = r_wen;
  assign bus.sram_cen   = r_cen;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
`default_nettype wire
